doppler_ramp_sequencer: RTL and testbench

//  Drives the 32-bit doppler_shift phase increment into the NCO / frequency-shift datapath.

---
 rtl/doppler_ramp_sequencer_if.sv | 27 ++
 rtl/doppler_ramp_sequencer.sv | 161 ++++++++++++++++
 tb/tb_doppler_ramp_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/doppler_ramp_sequencer_if.sv
// Control/config and NCO-side signal bundle for doppler_ramp_sequencer.
// master drives config/control, slave is the sequencer itself.
interface doppler_ramp_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             cfg_wr;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_data;
  logic             start;
  logic             abort;
  logic             sample_strobe;
  logic [31:0]      doppler_shift;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] step_index;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, start, abort, sample_strobe,
    input  doppler_shift, busy, done, cfg_err, step_index
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, start, abort, sample_strobe,
    output doppler_shift, busy, done, cfg_err, step_index
  );
endinterface

// File: rtl/doppler_ramp_sequencer.sv
// Doppler ramp sequencer: steps the NCO phase increment through a programmed ramp,
// dwelling on qualified sample strobes. Define DOPPLER_RAMP_TRIANGLE_EN for a repeating triangle ramp.
module doppler_ramp_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                     M100CLK,
  input  logic                     reset_n,
  doppler_ramp_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

  state_t                  state_p0, state_nxt;

  // Programmed registers, and working copies latched when a ramp starts
  logic signed [31:0]      start_cfg, step_cfg;
  logic [CNT_W-1:0]        nsteps_cfg, dwell_cfg;
  logic signed [31:0]      step_w;
  logic [CNT_W-1:0]        nsteps_w, dwell_last_w, last_idx;

  logic signed [31:0]      shift_p0, shift_nxt;
  logic [CNT_W-1:0]        idx_p0, idx_nxt;
  logic [CNT_W-1:0]        dwell_p0, dwell_nxt;
  logic                    cfg_err_p0;
  logic                    capture;
`ifdef DOPPLER_RAMP_TRIANGLE_EN
  logic                    dir_up_p0, dir_up_nxt;
`endif

  function automatic logic [CNT_W-1:0] dwell_limit(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - ONE;
  endfunction

  assign last_idx = nsteps_w - ONE;

  always_ff @(posedge M100CLK) begin
    if (!reset_n) state_p0 <= IDLE;
    else          state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    shift_nxt = shift_p0;
    idx_nxt   = idx_p0;
    dwell_nxt = dwell_p0;
    capture   = 1'b0;
`ifdef DOPPLER_RAMP_TRIANGLE_EN
    dir_up_nxt = dir_up_p0;
`endif
    if (bus.abort) begin
      state_nxt = IDLE;
      shift_nxt = '0;
      idx_nxt   = '0;
      dwell_nxt = '0;
`ifdef DOPPLER_RAMP_TRIANGLE_EN
      dir_up_nxt = 1'b1;
`endif
    end else begin
      case (state_p0)
        IDLE: begin
          if (bus.start) begin
            if (nsteps_cfg == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt = RAMP;
              shift_nxt = start_cfg;
              idx_nxt   = '0;
              dwell_nxt = '0;
              capture   = 1'b1;
`ifdef DOPPLER_RAMP_TRIANGLE_EN
              dir_up_nxt = 1'b1;
`endif
            end
          end
        end
        RAMP: begin
          if (bus.sample_strobe) begin
            if (dwell_p0 < dwell_last_w) begin
              dwell_nxt = dwell_p0 + ONE;
`ifdef DOPPLER_RAMP_TRIANGLE_EN
            end else if (nsteps_w > ONE) begin
              // Reverse at either end of the ramp; a single-step ramp just holds START
              dwell_nxt = '0;
              if ((dir_up_p0 && (idx_p0 < last_idx)) || (!dir_up_p0 && (idx_p0 == '0))) begin
                shift_nxt  = shift_p0 + step_w;
                idx_nxt    = idx_p0 + ONE;
                dir_up_nxt = 1'b1;
              end else begin
                shift_nxt  = shift_p0 - step_w;
                idx_nxt    = idx_p0 - ONE;
                dir_up_nxt = 1'b0;
              end
            end
`else
            end else if (idx_p0 < last_idx) begin
              dwell_nxt = '0;
              shift_nxt = shift_p0 + step_w;
              idx_nxt   = idx_p0 + ONE;
            end else begin
              state_nxt = DONE;
            end
`endif
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register stage: config, working copies and ramp datapath
  always_ff @(posedge M100CLK) begin
    if (!reset_n) begin
      start_cfg    <= '0;
      step_cfg     <= '0;
      nsteps_cfg   <= '0;
      dwell_cfg    <= '0;
      step_w       <= '0;
      nsteps_w     <= '0;
      dwell_last_w <= '0;
      shift_p0     <= '0;
      idx_p0       <= '0;
      dwell_p0     <= '0;
      cfg_err_p0   <= 1'b0;
`ifdef DOPPLER_RAMP_TRIANGLE_EN
      dir_up_p0    <= 1'b1;
`endif
    end else begin
      shift_p0   <= shift_nxt;
      idx_p0     <= idx_nxt;
      dwell_p0   <= dwell_nxt;
      cfg_err_p0 <= bus.cfg_wr && (state_p0 == RAMP);
`ifdef DOPPLER_RAMP_TRIANGLE_EN
      dir_up_p0  <= dir_up_nxt;
`endif
      if (bus.cfg_wr && (state_p0 != RAMP)) begin
        case (bus.cfg_addr)
          2'd0:    start_cfg  <= bus.cfg_data;
          2'd1:    step_cfg   <= bus.cfg_data;
          2'd2:    nsteps_cfg <= bus.cfg_data[CNT_W-1:0];
          default: dwell_cfg  <= bus.cfg_data[CNT_W-1:0];
        endcase
      end
      // Sampled before any same-edge write lands, so a ramp always runs on the old values
      if (capture) begin
        step_w       <= step_cfg;
        nsteps_w     <= nsteps_cfg;
        dwell_last_w <= dwell_limit(dwell_cfg);
      end
    end
  end

  assign bus.doppler_shift = shift_p0;
  assign bus.step_index    = idx_p0;
  assign bus.busy          = (state_p0 == RAMP);
  assign bus.done          = (state_p0 == DONE);
  assign bus.cfg_err       = cfg_err_p0;

endmodule

// File: tb/tb_doppler_ramp_sequencer.sv
// Directed self-checking bench for doppler_ramp_sequencer with hand-computed expectations.
module tb_doppler_ramp_sequencer;

  logic M100CLK = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always #5 M100CLK = ~M100CLK;

  doppler_ramp_sequencer_if #(.CNT_W(16)) bus ();

  doppler_ramp_sequencer #(.CNT_W(16)) dut (
    .M100CLK (M100CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge M100CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    bus.cfg_wr   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    tick();
    bus.cfg_wr   = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] st, input logic [31:0] sp,
                          input logic [31:0] ns, input logic [31:0] dw);
    cfg_write(2'd0, st);
    cfg_write(2'd1, sp);
    cfg_write(2'd2, ns);
    cfg_write(2'd3, dw);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_shift [6];
    logic [31:0] exp_idx   [6];
    logic        exp_busy  [6];
    logic        exp_done  [6];
    int          s;
    int          done_cnt;
    int          busy_seen;

    bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.sample_strobe = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    check_eq("rst_shift", bus.doppler_shift, 32'h0);
    check_eq("rst_busy",  {31'd0, bus.busy},    32'h0);
    check_eq("rst_done",  {31'd0, bus.done},    32'h0);
    check_eq("rst_err",   {31'd0, bus.cfg_err}, 32'h0);
    check_eq("rst_idx",   {16'd0, bus.step_index}, 32'h0);

`ifdef DOPPLER_RAMP_TRIANGLE_EN
    // Triangle: 0,1,2,1,0,1,2,1 with no done
    load_cfg(32'h0000_0100, 32'h0000_0010, 32'd3, 32'd1);
    bus.sample_strobe = 1'b1;
    pulse_start();
    check_eq("tri_start", bus.doppler_shift, 32'h100);
    begin
      int seq [8] = '{1, 2, 1, 0, 1, 2, 1, 0};
      for (int i = 0; i < 8; i++) begin
        tick();
        check_eq($sformatf("tri_idx%0d", i), {16'd0, bus.step_index}, seq[i]);
        check_eq($sformatf("tri_shift%0d", i), bus.doppler_shift, 32'h100 + 32'h10 * seq[i]);
        check_eq($sformatf("tri_busy%0d", i), {31'd0, bus.busy}, 32'd1);
        check_eq($sformatf("tri_done%0d", i), {31'd0, bus.done}, 32'd0);
      end
    end
    bus.sample_strobe = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("tri_abort_shift", bus.doppler_shift, 32'h0);
    check_eq("tri_abort_busy",  {31'd0, bus.busy}, 32'h0);
`else
    // Basic ramp, strobe every cycle
    load_cfg(32'h0001_0000, 32'h0000_0100, 32'd3, 32'd2);
    bus.sample_strobe = 1'b1;
    pulse_start();
    check_eq("t1_start_shift", bus.doppler_shift, 32'h0001_0000);
    check_eq("t1_start_busy",  {31'd0, bus.busy}, 32'd1);
    exp_shift = '{32'h10000, 32'h10100, 32'h10100, 32'h10200, 32'h10200, 32'h10200};
    exp_idx   = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2};
    exp_busy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_done  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("t1_shift%0d", i), bus.doppler_shift, exp_shift[i]);
      check_eq($sformatf("t1_idx%0d", i),   {16'd0, bus.step_index}, exp_idx[i]);
      check_eq($sformatf("t1_busy%0d", i),  {31'd0, bus.busy}, {31'd0, exp_busy[i]});
      check_eq($sformatf("t1_done%0d", i),  {31'd0, bus.done}, {31'd0, exp_done[i]});
    end
    bus.sample_strobe = 1'b0;
    tick();
    check_eq("t1_after_done", {31'd0, bus.done}, 32'd0);
    check_eq("t1_hold_shift", bus.doppler_shift, 32'h10200);

    // Strobe every 4th cycle; ramp ends on the 6th strobe
    pulse_start();
    check_eq("t2_start_shift", bus.doppler_shift, 32'h10000);
    s = 0;
    for (int c = 0; c < 28; c++) begin
      logic [31:0] es;
      bus.sample_strobe = (c % 4 == 0);
      tick();
      if (bus.sample_strobe && s < 6) s++;
      es = 32'h10000 + 32'h100 * ((s / 2 > 2) ? 2 : s / 2);
      check_eq($sformatf("t2_shift_c%0d", c), bus.doppler_shift, es);
      check_eq($sformatf("t2_done_c%0d", c), {31'd0, bus.done},
               {31'd0, (bus.sample_strobe && s == 6 && c == 20)});
      check_eq($sformatf("t2_busy_c%0d", c), {31'd0, bus.busy}, {31'd0, (s < 6)});
    end
    bus.sample_strobe = 1'b0;

    // Empty ramp: one done pulse, no busy, output unchanged
    cfg_write(2'd2, 32'd0);
    done_cnt = 0; busy_seen = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.start = 1'b0;
      done_cnt += bus.done;
      busy_seen += bus.busy;
    end
    check_eq("t3_empty_done", done_cnt, 32'd1);
    check_eq("t3_empty_busy", busy_seen, 32'd0);
    check_eq("t3_empty_shift", bus.doppler_shift, 32'h10200);

    // DWELL=0 acts as DWELL=1
    load_cfg(32'h0000_0500, 32'h0000_0010, 32'd2, 32'd0);
    bus.sample_strobe = 1'b1;
    pulse_start();
    check_eq("t3_dw0_start", bus.doppler_shift, 32'h500);
    tick();
    check_eq("t3_dw0_step", bus.doppler_shift, 32'h510);
    tick();
    check_eq("t3_dw0_done", {31'd0, bus.done}, 32'd1);
    bus.sample_strobe = 1'b0;
    tick();

    // Wrap through zero
    load_cfg(32'hFFFF_FF00, 32'h0000_0100, 32'd2, 32'd1);
    bus.sample_strobe = 1'b1;
    pulse_start();
    check_eq("t3_wrap_start", bus.doppler_shift, 32'hFFFF_FF00);
    tick();
    check_eq("t3_wrap_step", bus.doppler_shift, 32'h0000_0000);
    tick();
    check_eq("t3_wrap_done", {31'd0, bus.done}, 32'd1);
    bus.sample_strobe = 1'b0;
    tick();

    // Negative step
    load_cfg(32'h0000_1000, 32'hFFFF_FF00, 32'd3, 32'd1);
    bus.sample_strobe = 1'b1;
    pulse_start();
    tick();
    check_eq("t3_neg_step1", bus.doppler_shift, 32'h0000_0F00);
    tick();
    check_eq("t3_neg_step2", bus.doppler_shift, 32'h0000_0E00);
    check_eq("t3_neg_idx2",  {16'd0, bus.step_index}, 32'd2);
    tick();
    check_eq("t3_neg_done", {31'd0, bus.done}, 32'd1);
    bus.sample_strobe = 1'b0;
    tick();

    // Abort at step 1
    load_cfg(32'h0001_0000, 32'h0000_0100, 32'd3, 32'd2);
    bus.sample_strobe = 1'b1;
    pulse_start();
    tick(); tick();
    bus.sample_strobe = 1'b0;
    check_eq("t4_pre_idx",   {16'd0, bus.step_index}, 32'd1);
    check_eq("t4_pre_shift", bus.doppler_shift, 32'h10100);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("t4_ab_shift", bus.doppler_shift, 32'h0);
    check_eq("t4_ab_idx",   {16'd0, bus.step_index}, 32'd0);
    check_eq("t4_ab_busy",  {31'd0, bus.busy}, 32'd0);
    check_eq("t4_ab_done",  {31'd0, bus.done}, 32'd0);
    tick();
    check_eq("t4_ab_done2", {31'd0, bus.done}, 32'd0);

    // Abort and start together: no ramp
    bus.abort = 1'b1; bus.start = 1'b1;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0;
    check_eq("t4_as_busy",  {31'd0, bus.busy}, 32'd0);
    check_eq("t4_as_shift", bus.doppler_shift, 32'h0);
    tick();
    check_eq("t4_as_busy2", {31'd0, bus.busy}, 32'd0);
    check_eq("t4_as_done2", {31'd0, bus.done}, 32'd0);

    // Write with start: ramp uses the old START, the write still lands
    bus.cfg_wr = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 32'h0000_7777;
    bus.start  = 1'b1;
    tick();
    bus.cfg_wr = 1'b0; bus.start = 1'b0;
    check_eq("t4_wrstart_old", bus.doppler_shift, 32'h0001_0000);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    pulse_start();
    check_eq("t4_wrstart_new", bus.doppler_shift, 32'h0000_7777);

    // Write in RAMP rejected
    bus.cfg_wr = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_data = 32'h0000_0005;
    bus.sample_strobe = 1'b1;
    tick();
    bus.cfg_wr = 1'b0;
    check_eq("t5_err_pulse", {31'd0, bus.cfg_err}, 32'd1);
    tick();
    check_eq("t5_err_clear", {31'd0, bus.cfg_err}, 32'd0);
    check_eq("t5_step_kept", bus.doppler_shift, 32'h0000_7877);
    bus.sample_strobe = 1'b0;

    // Reset mid-ramp
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("t5_rst_shift", bus.doppler_shift, 32'h0);
    check_eq("t5_rst_busy",  {31'd0, bus.busy}, 32'd0);
    check_eq("t5_rst_idx",   {16'd0, bus.step_index}, 32'd0);
    done_cnt = 0; busy_seen = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.start = 1'b0;
      done_cnt += bus.done;
      busy_seen += bus.busy;
    end
    check_eq("t5_rst_cfg_done", done_cnt, 32'd1);
    check_eq("t5_rst_cfg_busy", busy_seen, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
